riscv_mem_stage: RTL and testbench
==================================

Name: riscv_mem_stage

Overview:
- Memory-access / write-back stage of the riscv hart pipeline. Sits directly downstream of EX.
- Consumes the EX result, store data and destination register.
- Performs byte/half/word loads and stores against a data-memory port using a req/ready handshake, and produces the register-file write-back.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 32, data/address width; only 32 is supported (RV32I lane logic).
- REGA, 5, register-index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  EX presents an instruction this cycle
- in_ready  out  1  stage can accept; high only in IDLE
- in_kind  in  2  0=ALU, 1=LOAD, 2=STORE, 3=bubble
- in_funct3  in  3  load/store width code (ignored for ALU)
- in_result  in  XLEN  ALU result, or effective address for LOAD/STORE
- in_bypass  in  XLEN  store data (rs2)
- in_rd  in  REGA  destination register
- mem_req  out  1  data-memory request, held until accepted
- mem_we  out  1  1=store, 0=load
- mem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  XLEN  lane-replicated store data
- mem_be  out  XLEN/8  byte enables
- mem_ready  in  1  memory accepts; for loads mem_rdata is valid in the same cycle
- mem_rdata  in  XLEN  load data word
- wb_en  out  1  register write strobe (one cycle)
- wb_rd  out  REGA  write index
- wb_data  out  XLEN  write data

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - All outputs reset to 0 except in_ready, which is 1 (IDLE).
  - Asserting reset mid-transaction drops mem_req immediately, discards the pending op and returns to IDLE. No write-back occurs.
- FSM states: IDLE, ACCESS, WB.
- IDLE:
  - A transfer happens when in_valid && in_ready.
  - ALU or bubble: register the result and go to IDLE. wb_en pulses the next cycle (1-cycle latency) if kind==ALU and rd!=0. Back-to-back ALU ops sustain 1/cycle.
  - LOAD/STORE with legal funct3: latch addr, data, funct3 and rd, then go to ACCESS.
- ACCESS:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata stay stable until mem_ready.
  - On mem_ready: a load captures the extracted data and goes to WB; a store goes to IDLE with no wb.
- WB: wb_en=1 for one cycle if rd!=0, then IDLE. in_ready=0 in ACCESS and WB.
- Load latency: 2 cycles plus memory wait states from acceptance to wb_en. A zero-wait store blocks for 1 cycle.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is treated as a bubble: no memory access, no wb.
- Lane selection uses off=addr[1:0].
  - Loads extract byte [8*off+:8] or half [16*off[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend.
  - Store byte enables: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111.
  - Store data: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
- rd==0 never produces wb_en, including for loads (the memory read is still performed).
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0. Handling depends on the optional feature below.

Optional Feature:
- Macro: RISCV_MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1) and misalign_addr (XLEN).
  - A misaligned LOAD/STORE is not issued to memory and produces no wb.
  - misalign pulses high for one cycle, one cycle after acceptance; misalign_addr holds the offending address until the next misaligned access. Both reset to 0.
- Undefined: a misaligned access is performed aligned down: off is treated as 0 for half/word, i.e. half uses off[1] only and word uses lane 0.

Test Plan:
- After reset, ALU kind, rd=5, result=0x1234_5678 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1234_5678; three back-to-back ALU ops -> three consecutive wb pulses.
- LB addr=0x103, mem_rdata=0x80FF_0000, zero-wait -> mem_addr=0x100, mem_be=0, mem_we=0; wb_data=0xFFFF_FF80. LBU same -> 0x0000_0080.
- SH addr=0x202, data=0xAAAA_BEEF, mem_ready delayed 3 cycles -> mem_req held 4 cycles with mem_be=4'b1100, mem_wdata=0xBEEF_BEEF; in_ready=0 throughout; no wb.
- LW addr=0x40 with rd=0 -> mem_req issued, wb_en stays 0; funct3=011 load -> no mem_req, no wb.
- Reset asserted during ACCESS with mem_ready=0 -> mem_req=0 in the same cycle, in_ready=1; a following ALU op completes normally.
- LW addr=0x41: with RISCV_MEM_MISALIGN_TRAP_EN -> no mem_req, misalign pulse, misalign_addr=0x41; without -> mem_addr=0x40, full word returned.

Source files
------------

// File: rtl/riscv_mem_stage.sv
// Memory-access / write-back stage: byte/half/word loads and stores over a req/ready port.
// Build option RISCV_MEM_MISALIGN_TRAP_EN: flag misaligned accesses instead of aligning them down.
module riscv_mem_stage #(
  parameter int XLEN = 32,
  parameter int REGA = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_bypass,
  input  logic [REGA-1:0]   in_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_en,
  output logic [REGA-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  output logic              misalign,
  output logic [XLEN-1:0]   misalign_addr,
`endif
  output logic [1:0]        debug_state
);

  // Handshakes: EX->stage transfers on in_valid && in_ready; stage->memory
  // completes on mem_req && mem_ready, with mem_* held stable until then.

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WB = 2'd2} state_t;

  localparam logic [1:0] KIND_ALU   = 2'd0;
  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_STORE = 2'd2;

  state_t            state;
  logic [2:0]        op_f3;
  logic [1:0]        op_off;
  logic [REGA-1:0]   op_rd;

  logic              is_load;
  logic              is_store;
  logic              f3_legal;
  logic [1:0]        off;
  logic [1:0]        eff_off;
  logic [XLEN/8-1:0] be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_ext;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  logic              misal;
`endif

  assign debug_state = state;

  always_comb begin
    is_load  = (in_kind == KIND_LOAD);
    is_store = (in_kind == KIND_STORE);
    f3_legal = 1'b0;
    if (is_load)
      f3_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                 (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    else if (is_store)
      f3_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    off = in_result[1:0];
    // Halves keep only off[1] and words use lane 0, which also aligns down misaligned ops.
    case (in_funct3[1:0])
      2'b00:   eff_off = off;
      2'b01:   eff_off = {off[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
    case (in_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << eff_off;
        wdata_c = {4{in_bypass[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << eff_off;
        wdata_c = {2{in_bypass[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = in_bypass;
      end
    endcase
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    misal = ((in_funct3[1:0] == 2'b01) && off[0]) ||
            ((in_funct3[1:0] == 2'b10) && (off != 2'b00));
`endif
  end

  always_comb begin
    shifted = mem_rdata >> {op_off, 3'b000};
    case (op_f3)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      op_f3     <= '0;
      op_off    <= '0;
      op_rd     <= '0;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
      misalign      <= 1'b0;
      misalign_addr <= '0;
`endif
    end else begin
      wb_en <= 1'b0;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_kind == KIND_ALU) begin
              wb_en   <= (in_rd != '0);
              wb_rd   <= in_rd;
              wb_data <= in_result;
            end else if ((is_load || is_store) && f3_legal) begin
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
              if (misal) begin
                misalign      <= 1'b1;
                misalign_addr <= in_result;
              end else begin
`else
              begin
`endif
                state     <= ACCESS;
                in_ready  <= 1'b0;
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {in_result[XLEN-1:2], 2'b00};
                mem_be    <= is_store ? be_c : '0;
                mem_wdata <= is_store ? wdata_c : '0;
                op_f3     <= in_funct3;
                op_off    <= eff_off;
                op_rd     <= in_rd;
              end
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            if (mem_we) begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end else begin
              state   <= WB;
              wb_en   <= (op_rd != '0);
              wb_rd   <= op_rd;
              wb_data <= load_ext;
            end
          end
        end
        WB: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_stage.sv
// Directed bench for riscv_mem_stage: ALU write-back, loads, stores, reset abort, misalignment.
`timescale 1ns/1ps
module tb_riscv_mem_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic [31:0] in_bypass;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  debug_state;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
  logic        misalign;
  logic [31:0] misalign_addr;
`endif

  int n_checks;
  int n_fail;

  riscv_mem_stage #(.XLEN(32), .REGA(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_funct3(in_funct3),
    .in_result(in_result), .in_bypass(in_bypass), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    .misalign(misalign), .misalign_addr(misalign_addr),
`endif
    .debug_state(debug_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] res,
                       input logic [31:0] byp, input logic [4:0] rd);
    in_valid  = 1'b1;
    in_kind   = kind;
    in_funct3 = f3;
    in_result = res;
    in_bypass = byp;
    in_rd     = rd;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_kind  = 2'd3;
  endtask

  // Zero-wait load: issue, check request, then check write-back.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
    drive(2'd1, f3, addr, 32'h0, rd);
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    idle_in();
    check_eq({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    check_eq({tag, "_addr"}, mem_addr, exp_addr);
    check_eq({tag, "_be"}, {28'd0, mem_be}, 32'd0);
    check_eq({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    tick();
    check_eq({tag, "_wben"}, {31'd0, wb_en}, {31'd0, (rd != 5'd0)});
    if (rd != 5'd0) begin
      check_eq({tag, "_wbdata"}, wb_data, exp_data);
      check_eq({tag, "_wbrd"}, {27'd0, wb_rd}, {27'd0, rd});
    end
    check_eq({tag, "_reqdrop"}, {31'd0, mem_req}, 32'd0);
    tick();
    check_eq({tag, "_back"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_wboff"}, {31'd0, wb_en}, 32'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_kind   = 2'd3;
    in_funct3 = 3'd0;
    in_result = 32'd0;
    in_bypass = 32'd0;
    in_rd     = 5'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    tick();
    tick();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_wb_en", {31'd0, wb_en}, 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    check_eq("rst_state", {30'd0, debug_state}, 32'd0);
    rst = 1'b0;

    // single ALU op
    drive(2'd0, 3'd0, 32'h1234_5678, 32'h0, 5'd5);
    tick();
    idle_in();
    check_eq("alu_wben", {31'd0, wb_en}, 32'd1);
    check_eq("alu_wbrd", {27'd0, wb_rd}, 32'd5);
    check_eq("alu_wbdata", wb_data, 32'h1234_5678);
    tick();
    check_eq("alu_wbpulse", {31'd0, wb_en}, 32'd0);

    // three back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(2'd0, 3'd0, 32'hA000_0000 + i, 32'h0, 5'(i + 1));
      else idle_in();
      if (i > 0) begin
        check_eq("b2b_rdy", {31'd0, in_ready}, 32'd1);
      end
      tick();
      if (i < 3) begin
        check_eq("b2b_wben", {31'd0, wb_en}, 32'd1);
        check_eq("b2b_wbdata", wb_data, 32'hA000_0000 + i);
        check_eq("b2b_wbrd", {27'd0, wb_rd}, i + 1);
      end else begin
        check_eq("b2b_end", {31'd0, wb_en}, 32'd0);
      end
    end

    // ALU to x0 and bubble: no write-back
    drive(2'd0, 3'd0, 32'h5555_5555, 32'h0, 5'd0);
    tick();
    check_eq("alu_x0", {31'd0, wb_en}, 32'd0);
    drive(2'd3, 3'd0, 32'h6666_6666, 32'h0, 5'd9);
    tick();
    idle_in();
    check_eq("bubble_wb", {31'd0, wb_en}, 32'd0);
    check_eq("bubble_req", {31'd0, mem_req}, 32'd0);

    // loads
    do_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_0000, 5'd7, 32'h0000_0100, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 5'd7, 32'h0000_0100, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h0000_0102, 32'h80FF_0000, 5'd8, 32'h0000_0100, 32'hFFFF_80FF);
    do_load("lhu", 3'b101, 32'h0000_0102, 32'h80FF_0000, 5'd8, 32'h0000_0100, 32'h0000_80FF);
    do_load("lb1", 3'b000, 32'h0000_0011, 32'h1234_7F00, 5'd3, 32'h0000_0010, 32'h0000_007F);
    do_load("lw",  3'b010, 32'h0000_0044, 32'hDEAD_BEEF, 5'd4, 32'h0000_0044, 32'hDEAD_BEEF);
    do_load("lw0", 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 5'd0, 32'h0000_0040, 32'h0);

    // SH with three wait states
    drive(2'd2, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd6);
    mem_ready = 1'b0;
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      check_eq("sh_req", {31'd0, mem_req}, 32'd1);
      check_eq("sh_we", {31'd0, mem_we}, 32'd1);
      check_eq("sh_be", {28'd0, mem_be}, 32'h0000_000C);
      check_eq("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      check_eq("sh_addr", mem_addr, 32'h0000_0200);
      check_eq("sh_rdy", {31'd0, in_ready}, 32'd0);
      check_eq("sh_wb", {31'd0, wb_en}, 32'd0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check_eq("sh_done_req", {31'd0, mem_req}, 32'd0);
    check_eq("sh_done_rdy", {31'd0, in_ready}, 32'd1);
    check_eq("sh_done_wb", {31'd0, wb_en}, 32'd0);

    // SB lane 1, zero wait
    drive(2'd2, 3'b000, 32'h0000_0301, 32'h1234_56A5, 5'd6);
    mem_ready = 1'b1;
    tick();
    idle_in();
    check_eq("sb_be", {28'd0, mem_be}, 32'h0000_0002);
    check_eq("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    tick();
    mem_ready = 1'b0;
    check_eq("sb_rdy", {31'd0, in_ready}, 32'd1);
    check_eq("sb_wb", {31'd0, wb_en}, 32'd0);

    // illegal load width is a bubble
    drive(2'd1, 3'b011, 32'h0000_0040, 32'h0, 5'd9);
    tick();
    idle_in();
    check_eq("ill_req", {31'd0, mem_req}, 32'd0);
    check_eq("ill_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("ill_wb", {31'd0, wb_en}, 32'd0);

    // reset while waiting on memory
    drive(2'd1, 3'b010, 32'h0000_0080, 32'h0, 5'd10);
    tick();
    idle_in();
    check_eq("rstacc_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rstacc_reqdrop", {31'd0, mem_req}, 32'd0);
    check_eq("rstacc_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    check_eq("rstacc_wb", {31'd0, wb_en}, 32'd0);
    drive(2'd0, 3'd0, 32'h0BAD_F00D, 32'h0, 5'd11);
    tick();
    idle_in();
    check_eq("post_rst_wben", {31'd0, wb_en}, 32'd1);
    check_eq("post_rst_wbdata", wb_data, 32'h0BAD_F00D);
    tick();

    // misaligned LW at 0x41
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    drive(2'd1, 3'b010, 32'h0000_0041, 32'h0, 5'd12);
    mem_ready = 1'b1;
    mem_rdata = 32'h1122_3344;
    tick();
    idle_in();
    check_eq("mis_req", {31'd0, mem_req}, 32'd0);
    check_eq("mis_pulse", {31'd0, misalign}, 32'd1);
    check_eq("mis_addr", misalign_addr, 32'h0000_0041);
    check_eq("mis_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("mis_pulse_end", {31'd0, misalign}, 32'd0);
    check_eq("mis_addr_hold", misalign_addr, 32'h0000_0041);
    check_eq("mis_wb", {31'd0, wb_en}, 32'd0);
    mem_ready = 1'b0;
`else
    do_load("lwmis", 3'b010, 32'h0000_0041, 32'h1122_3344, 5'd12, 32'h0000_0040, 32'h1122_3344);
    do_load("lhmis", 3'b001, 32'h0000_0043, 32'h8765_4321, 5'd13, 32'h0000_0040, 32'hFFFF_8765);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
